// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory controller: access-size encoding,
// FSM state type and the address-check / lane-merge / read-extract helpers.
package datamem_pkg;

  // Access size encoding as seen on size0/size1.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Number of bytes touched by an access; the illegal code maps to zero.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // True when the access is misaligned, uses the illegal size code or runs
  // past the end of memory. 33-bit sum so addresses near 2^32 cannot wrap.
  function automatic logic is_illegal(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [32:0] mem_limit);
    logic [32:0] end_addr;
    logic        bad;
    end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || (end_addr > mem_limit);
  endfunction

  // Replace only the addressed byte lane(s) of 'old' with right-aligned wdata.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    data = wdata << {off, 3'b000};
    return (old & ~mask) | (data & mask);
  endfunction

  // Shift the addressed lane(s) down to bit 0 and zero-extend.
  function automatic logic [31:0] extract_read(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = {24'd0, sh[7:0]};
      SZ_HALF: res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/datamem_ctrl_if.sv
// Bus bundle between the two requesters, the controller and the data memory.
interface datamem_ctrl_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [1:0]  size0;
  logic [1:0]  size1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;

  // Controller side.
  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output memWrite, memAddr, memWData,
    input  memRData
  );

  // Requesters plus memory side (the environment around the controller).
  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  memWrite, memAddr, memWData,
    output memRData
  );
endinterface

// File: rtl/datamem_rr_arb.sv
// Two-port round-robin arbiter. Priority starts at port 0 and moves to the
// port that was not granted after every grant; a lone request wins at once.
module datamem_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic prio_r;  // 0: port 0 preferred, 1: port 1 preferred

  // Pick the winner from the current requests and the priority pointer.
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio_r;
      default: gnt_idx = 1'b0;
    endcase
  end

  // Hand priority to the other port whenever a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (grant_en && gnt_valid) begin
      prio_r <= ~gnt_idx;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/datamem_ctrl.sv
// Two-port data-memory controller: arbitrates CPU and debug-loader requests,
// rejects illegal accesses, performs word accesses directly and sub-word
// writes as read-merge-write against a word-wide memory.
module datamem_ctrl
  import datamem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  datamem_ctrl_if.slave bus
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_r;
  state_t      state_n;

  logic        gnt_valid_s;
  logic        gnt_idx_s;
  logic        grant_en_s;

  logic        sel_we_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_illegal_s;

  logic        lat_port_r;
  logic        lat_we_r;
  logic [1:0]  lat_size_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [31:0] cap_r;

  logic        port_n_s;
  logic        err_n_s;
  logic [31:0] rd_s;

  logic        mem_write_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;

  logic        ack0_r;
  logic        ack1_r;
  logic        err0_r;
  logic        err1_r;
  logic [31:0] rdata0_r;
  logic [31:0] rdata1_r;

  assign grant_en_s = (state_r == ST_IDLE);

  datamem_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({bus.req1, bus.req0}),
    .grant_en  (grant_en_s),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Route the winning port's qualifiers and classify the request.
  always_comb begin
    sel_we_s      = gnt_idx_s ? bus.we1    : bus.we0;
    sel_size_s    = gnt_idx_s ? bus.size1  : bus.size0;
    sel_addr_s    = gnt_idx_s ? bus.addr1  : bus.addr0;
    sel_wdata_s   = gnt_idx_s ? bus.wdata1 : bus.wdata0;
    sel_illegal_s = is_illegal(sel_size_s, sel_addr_s, MEM_LIMIT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_n = sel_illegal_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (lat_we_r && (lat_size_r != SZ_WORD)) begin
          state_n = ST_MERGE_WR;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_MERGE_WR: state_n = ST_DONE;
      ST_DONE:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // Latch the granted request; later input changes are ignored until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_port_r  <= 1'b0;
      lat_we_r    <= 1'b0;
      lat_size_r  <= 2'b00;
      lat_addr_r  <= 32'd0;
      lat_wdata_r <= 32'd0;
    end else if (grant_en_s && gnt_valid_s) begin
      lat_port_r  <= gnt_idx_s;
      lat_we_r    <= sel_we_s;
      lat_size_r  <= sel_size_s;
      lat_addr_r  <= sel_addr_s;
      lat_wdata_r <= sel_wdata_s;
    end else begin
      lat_port_r  <= lat_port_r;
      lat_we_r    <= lat_we_r;
      lat_size_r  <= lat_size_r;
      lat_addr_r  <= lat_addr_r;
      lat_wdata_r <= lat_wdata_r;
    end
  end

  // Capture the memory word read during ACCESS for the merge step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r <= 32'd0;
    end else if (state_r == ST_ACCESS) begin
      cap_r <= bus.memRData;
    end else begin
      cap_r <= cap_r;
    end
  end

  // Values the completion registers take on the next edge. Only an illegal
  // request goes straight from IDLE to DONE, which is what flags the error.
  always_comb begin
    port_n_s = (state_r == ST_IDLE) ? gnt_idx_s : lat_port_r;
    err_n_s  = (state_r == ST_IDLE) && (state_n == ST_DONE);
    rd_s     = extract_read(bus.memRData, lat_size_r, lat_addr_r[1:0]);
  end

  // Registered completion outputs: ack/err/rdata are high only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= 32'd0;
      rdata1_r <= 32'd0;
    end else begin
      ack0_r   <= (state_n == ST_DONE) && !port_n_s;
      ack1_r   <= (state_n == ST_DONE) &&  port_n_s;
      err0_r   <= err_n_s && !port_n_s;
      err1_r   <= err_n_s &&  port_n_s;
      rdata0_r <= ((state_r == ST_ACCESS) && !lat_we_r && !lat_port_r) ? rd_s : 32'd0;
      rdata1_r <= ((state_r == ST_ACCESS) && !lat_we_r &&  lat_port_r) ? rd_s : 32'd0;
    end
  end

  // Memory strobes decoded from state and latched request only, so an
  // asynchronous reset drops memWrite immediately.
  always_comb begin
    mem_write_s = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 32'd0;
    case (state_r)
      ST_ACCESS: begin
        mem_addr_s = {lat_addr_r[31:2], 2'b00};
        if (lat_we_r && (lat_size_r == SZ_WORD)) begin
          mem_write_s = 1'b1;
          mem_wdata_s = lat_wdata_r;
        end else begin
          mem_write_s = 1'b0;
          mem_wdata_s = 32'd0;
        end
      end
      ST_MERGE_WR: begin
        mem_addr_s  = {lat_addr_r[31:2], 2'b00};
        mem_write_s = 1'b1;
        mem_wdata_s = merge_lanes(cap_r, lat_wdata_r, lat_size_r, lat_addr_r[1:0]);
      end
      default: begin
        mem_write_s = 1'b0;
        mem_addr_s  = 32'd0;
        mem_wdata_s = 32'd0;
      end
    endcase
  end

  assign bus.ack0     = ack0_r;
  assign bus.ack1     = ack1_r;
  assign bus.err0     = err0_r;
  assign bus.err1     = err1_r;
  assign bus.rdata0   = rdata0_r;
  assign bus.rdata1   = rdata1_r;
  assign bus.memWrite = mem_write_s;
  assign bus.memAddr  = mem_addr_s;
  assign bus.memWData = mem_wdata_s;

endmodule
